vp_attr_delay_line: RTL and testbench

//  Parametrised, runtime-adjustable delay line for video-pipeline attribute bundles.

---
 rtl/vp_attr_delay_line_pkg.sv | 9 +
 rtl/vp_delay_ram.sv | 21 ++
 rtl/vp_attr_delay_line.sv | 78 +++++++
 tb/tb_vp_attr_delay_line.sv | 138 +++++++++++++
 4 files changed

// File: rtl/vp_attr_delay_line_pkg.sv
// Shared attribute-lane widths and delay defaults for the video pipeline.
package vp_attr_delay_line_pkg;
  localparam int COLOR_BITS           = 4;
  localparam int BITMAP_BITS          = 16;
  localparam int VP_ATTR_WIDTH        = 2*COLOR_BITS + BITMAP_BITS;
  localparam int VP_MAX_DELAY_DEFAULT = 8;
  // D=1 plus the output register gives a 2-cycle total latency
  localparam int VP_GFX_DELAY_DEFAULT = 1;
endpackage

// File: rtl/vp_delay_ram.sv
// Circular-buffer storage: one synchronous write port, one combinational read port.
// A read and a write to the same address in one cycle returns the old entry.
module vp_delay_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 25,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/vp_attr_delay_line.sv
// Runtime-adjustable delay line aligning attribute bundles with the pixel serialiser.
// A delay change or flush empties the line; out_valid stays low until it has refilled.
module vp_attr_delay_line
  import vp_attr_delay_line_pkg::*;
#(
  parameter int DATA_WIDTH = VP_ATTR_WIDTH,
  parameter int MAX_DELAY  = VP_MAX_DELAY_DEFAULT,
  parameter int DELAY_BITS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  input  logic                  flush,
  input  logic [DELAY_BITS-1:0] delay,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  primed
);
  localparam int PW = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam logic [DELAY_BITS-1:0] DMAX = DELAY_BITS'(MAX_DELAY);

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [DELAY_BITS-1:0] fill_cnt, delay_q, delay_c;
  logic [DATA_WIDTH:0]   rd_entry, sel_entry;
  logic                  dchg, fill_ok, we;
  int                    rd_tmp;

  assign delay_c = (delay > DMAX) ? DMAX : delay;
  assign dchg    = (delay_c != delay_q);
  assign fill_ok = (fill_cnt >= delay_q);
  assign we      = advance & ~reset & ~flush & ~dchg;

  always_comb begin
    rd_tmp = int'(wr_ptr) - int'(delay_q);
    if (rd_tmp < 0) rd_tmp = rd_tmp + MAX_DELAY;
    rd_ptr = PW'(rd_tmp);
  end

  // D=0 bypasses storage so the line degenerates to the output register
  assign sel_entry = (delay_q == '0) ? {in_valid, in_data} : rd_entry;

  vp_delay_ram #(
    .DEPTH (MAX_DELAY),
    .WIDTH (DATA_WIDTH + 1),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (wr_ptr),
    .wdata ({in_valid, in_data}),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      primed    <= 1'b0;
      wr_ptr    <= '0;
      fill_cnt  <= '0;
      delay_q   <= delay_c;
    end else if (flush || dchg) begin
      fill_cnt  <= '0;
      out_valid <= 1'b0;
      primed    <= 1'b0;
      delay_q   <= delay_c;
    end else if (advance) begin
      out_data  <= sel_entry[DATA_WIDTH-1:0];
      out_valid <= sel_entry[DATA_WIDTH] & fill_ok;
      primed    <= fill_ok;
      wr_ptr    <= (wr_ptr == PW'(MAX_DELAY - 1)) ? '0 : wr_ptr + PW'(1);
      if (fill_cnt != DMAX) fill_cnt <= fill_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_vp_attr_delay_line.sv
// Directed vector table plus hand-written flush/delay-change sequences.
module tb_vp_attr_delay_line;
  logic        clk = 1'b0;
  logic        reset, advance, flush, in_valid;
  logic [3:0]  delay;
  logic [23:0] in_data, out_data;
  logic        out_valid, primed;
  int          checks = 0;
  int          failures = 0;

  vp_attr_delay_line #(.DATA_WIDTH(24), .MAX_DELAY(8), .DELAY_BITS(4)) dut (
    .clk(clk), .reset(reset), .advance(advance), .flush(flush), .delay(delay),
    .in_data(in_data), .in_valid(in_valid),
    .out_data(out_data), .out_valid(out_valid), .primed(primed)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, adv, fl;
    logic [3:0]  dly;
    logic [23:0] din;
    logic        vin;
    logic        ev, ep, cd;
    logic [23:0] ed;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic rst, input logic adv, input logic fl,
                              input logic [3:0] dly, input logic [23:0] din, input logic vin,
                              input logic ev, input logic ep, input logic cd, input logic [23:0] ed);
    vec_t v;
    v.rst = rst; v.adv = adv; v.fl = fl; v.dly = dly; v.din = din; v.vin = vin;
    v.ev = ev; v.ep = ep; v.cd = cd; v.ed = ed;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input int row, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%0h exp=%0h", nm, row, act, exp);
    end
  endtask

  task automatic step(input logic rst, input logic adv, input logic fl,
                      input logic [3:0] dly, input logic [23:0] din);
    reset = rst; advance = adv; flush = fl; delay = dly; in_data = din; in_valid = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; advance = 1'b0; flush = 1'b0; delay = 4'd1; in_data = '0; in_valid = 1'b0;

    // D=1 ramp: first valid after the 2nd advancing edge, carrying sample 1
    add(1, 1, 0, 4'd1, 24'h0, 0, 0, 0, 1, 24'h0);
    for (int i = 1; i <= 10; i++)
      add(0, 1, 0, 4'd1, 24'(i), 1, i >= 2, i >= 2, i >= 2, 24'(i - 1));

    // D=0: plain register, valid from the first edge; one invalid sample
    add(1, 1, 0, 4'd0, 24'h0, 0, 0, 0, 1, 24'h0);
    for (int i = 1; i <= 6; i++)
      add(0, 1, 0, 4'd0, 24'h100 + 24'(i), i != 4, i != 4, 1, 1, 24'h100 + 24'(i));

    // D=8 with pointer wrap: first valid on edge 9
    add(1, 1, 0, 4'd8, 24'h0, 0, 0, 0, 1, 24'h0);
    for (int i = 1; i <= 20; i++)
      add(0, 1, 0, 4'd8, 24'(i), 1, i >= 9, i >= 9, i >= 9, 24'(i - 8));

    // D=3 with a two-cycle stall: outputs frozen, no sample lost
    add(1, 1, 0, 4'd3, 24'h0, 0, 0, 0, 1, 24'h0);
    for (int i = 1; i <= 4; i++)
      add(0, 1, 0, 4'd3, 24'(i), 1, i >= 4, i >= 4, i >= 4, 24'(i - 3));
    add(0, 0, 0, 4'd3, 24'hAA, 1, 1, 1, 1, 24'd1);
    add(0, 0, 0, 4'd3, 24'hAB, 1, 1, 1, 1, 24'd1);
    for (int i = 5; i <= 8; i++)
      add(0, 1, 0, 4'd3, 24'(i), 1, 1, 1, 1, 24'(i - 3));

    // D=4 flush: data holds, four invalid edges, then the first post-flush input
    add(1, 1, 0, 4'd4, 24'h0, 0, 0, 0, 1, 24'h0);
    for (int i = 1; i <= 6; i++)
      add(0, 1, 0, 4'd4, 24'(i), 1, i >= 5, i >= 5, i >= 5, 24'(i - 4));
    add(0, 1, 1, 4'd4, 24'h77, 1, 0, 0, 1, 24'd2);
    for (int j = 1; j <= 6; j++)
      add(0, 1, 0, 4'd4, 24'h50 + 24'(j), 1, j >= 5, j >= 5, j >= 5, 24'h50 + 24'(j - 4));

    // Delay 2 -> 5, then 15 (clamped to 8), then reset while primed
    add(1, 1, 0, 4'd2, 24'h0, 0, 0, 0, 1, 24'h0);
    for (int i = 1; i <= 5; i++)
      add(0, 1, 0, 4'd2, 24'(i), 1, i >= 3, i >= 3, i >= 3, 24'(i - 2));
    add(0, 1, 0, 4'd5, 24'h99, 1, 0, 0, 1, 24'd3);
    for (int j = 1; j <= 7; j++)
      add(0, 1, 0, 4'd5, 24'h60 + 24'(j), 1, j >= 6, j >= 6, j >= 6, 24'h60 + 24'(j - 5));
    add(0, 1, 0, 4'd15, 24'hEE, 1, 0, 0, 1, 24'h62);
    for (int j = 1; j <= 10; j++)
      add(0, 1, 0, 4'd15, 24'h80 + 24'(j), 1, j >= 9, j >= 9, j >= 9, 24'h80 + 24'(j - 8));
    add(1, 1, 0, 4'd15, 24'h33, 1, 0, 0, 1, 24'h0);
    add(0, 1, 0, 4'd15, 24'h34, 1, 0, 0, 0, 24'h0);

    for (int n = 0; n < vq.size(); n++) begin
      reset = vq[n].rst; advance = vq[n].adv; flush = vq[n].fl; delay = vq[n].dly;
      in_data = vq[n].din; in_valid = vq[n].vin;
      @(posedge clk); #1;
      chk("out_valid", n, 24'(out_valid), 24'(vq[n].ev));
      chk("primed", n, 24'(primed), 24'(vq[n].ep));
      if (vq[n].cd) chk("out_data", n, out_data, vq[n].ed);
    end

    // Flush and delay change together while stalled: one flush, new delay 3
    step(1, 1, 0, 4'd2, 24'h0);
    for (int i = 1; i <= 3; i++) step(0, 1, 0, 4'd2, 24'(i));
    chk("seq_pre_valid", 0, 24'(out_valid), 24'd1);
    chk("seq_pre_data", 0, out_data, 24'd1);
    step(0, 0, 1, 4'd3, 24'hAB);
    chk("seq_fl_valid", 0, 24'(out_valid), 24'd0);
    chk("seq_fl_primed", 0, 24'(primed), 24'd0);
    chk("seq_fl_data", 0, out_data, 24'd1);
    for (int j = 1; j <= 4; j++) begin
      step(0, 1, 0, 4'd3, 24'h40 + 24'(j));
      chk("seq_refill3_valid", j, 24'(out_valid), 24'(j >= 4));
    end
    chk("seq_refill3_data", 4, out_data, 24'h41);

    // Delay change with advance low still empties the line
    step(0, 0, 0, 4'd5, 24'hCD);
    chk("seq_dchg_valid", 0, 24'(out_valid), 24'd0);
    chk("seq_dchg_data", 0, out_data, 24'h41);
    for (int j = 1; j <= 6; j++) begin
      step(0, 1, 0, 4'd5, 24'h90 + 24'(j));
      chk("seq_refill5_valid", j, 24'(out_valid), 24'(j >= 6));
    end
    chk("seq_refill5_data", 6, out_data, 24'h91);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
